// File: rtl/cam_capture_fmt_if.sv
// Frame-buffer write channel: active-low frame sync, pixel valid and RGB565 pixel data.
interface cam_capture_fmt_if;
    logic        vs_n;
    logic        de;
    logic [15:0] data;

    modport master (output vs_n, de, data);
    modport slave  (input  vs_n, de, data);
endinterface

// File: rtl/cam_capture_fmt.sv
// OV2640 parallel-port capture: frame alignment with start-up frame skip,
// RGB565 byte pairing or RAW10-to-grey conversion, and H/V window crop
// feeding the frame buffer write channel.
module cam_capture_fmt #(
    parameter int unsigned H_START     = 0,
    parameter int unsigned V_START     = 0,
    parameter int unsigned H_RES       = 800,
    parameter int unsigned V_RES       = 600,
    parameter int unsigned SKIP_FRAMES = 2
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    input  logic              I_mode,
    input  logic              I_vsync,
    input  logic              I_href,
    input  logic [9:0]        I_pixdata,
    cam_capture_fmt_if.master o_fb,
    output logic              O_running,
    output logic [15:0]       O_frame_cnt,
    output logic              O_err
);

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned SKIP_W    = 16;
    localparam int unsigned FCNT_W    = 16;
    localparam int unsigned PIX_W     = 10;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned OFF_W     = 33;
    localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;
    localparam int unsigned SKIP_LAST = (SKIP_FRAMES == 0) ? 0 : SKIP_FRAMES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic [SKIP_W-1:0]   w_skip_cnt_nxt;

    logic                r_vsync1;
    logic                r_vsync2;
    logic                r_href1;
    logic                r_href2;
    logic [PIX_W-1:0]    r_pix1;

    logic                r_mode;
    logic                r_phase;
    logic [7:0]          r_hi;
    logic [CNT_W-1:0]    r_h_cnt;
    logic [CNT_W-1:0]    r_v_cnt;

    logic                r_vs_n;
    logic                r_de;
    logic [OUT_W-1:0]    r_data;
    logic                r_running;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic                r_err;

    logic                w_fs;
    logic                w_href_fall;
    logic                w_strobe;
    logic [OUT_W-1:0]    w_pix;
    logic [OFF_W-1:0]    w_h_off;
    logic [OFF_W-1:0]    w_v_off;
    logic                w_h_in;
    logic                w_v_in;
    logic                w_de;
    logic                w_unused_pix;

    // Input stage plus one extra copy of the sync signals for edge detection
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vsync1 <= 1'b0;
            r_vsync2 <= 1'b0;
            r_href1  <= 1'b0;
            r_href2  <= 1'b0;
            r_pix1   <= '0;
        end else begin
            r_vsync1 <= I_vsync;
            r_vsync2 <= r_vsync1;
            r_href1  <= I_href;
            r_href2  <= r_href1;
            r_pix1   <= I_pixdata;
        end
    end

    assign w_fs         = r_vsync1 & ~r_vsync2;
    assign w_href_fall  = r_href2 & ~r_href1;
    assign w_unused_pix = ^r_pix1[1:0];

    // RAW10 yields a pixel every line cycle; RGB565 on the second byte of each pair
    assign w_strobe = r_href1 & (r_mode | r_phase);
    assign w_pix    = r_mode ? {r_pix1[9:5], r_pix1[9:4], r_pix1[9:5]}
                             : {r_hi, r_pix1[9:2]};

    // Window test by subtraction so a zero start offset needs no special case
    assign w_h_off = OFF_W'(r_h_cnt) - OFF_W'(H_START);
    assign w_v_off = OFF_W'(r_v_cnt) - OFF_W'(V_START);
    assign w_h_in  = ~w_h_off[OFF_W-1] & (w_h_off[OFF_W-2:0] < H_RES);
    assign w_v_in  = ~w_v_off[OFF_W-1] & (w_v_off[OFF_W-2:0] < V_RES);
    assign w_de    = w_strobe & (r_state == S_RUN) & w_h_in & w_v_in;

    // Capture state register
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_cnt_nxt;
        end
    end

    // Next state: wait for a frame start, discard SKIP_FRAMES frames, then run
    always_comb begin
        w_state_nxt    = r_state;
        w_skip_cnt_nxt = r_skip_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_fs) begin
                    w_skip_cnt_nxt = '0;
                    w_state_nxt    = (SKIP_FRAMES == 0) ? S_RUN : S_SKIP;
                end
            end
            S_SKIP: begin
                if (w_fs) begin
                    if (r_skip_cnt == SKIP_W'(SKIP_LAST)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_skip_cnt_nxt = r_skip_cnt + SKIP_W'(1);
                    end
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Mode latch, byte pairing and the sticky odd-byte-count flag
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mode  <= 1'b0;
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_fs) begin
                r_mode <= I_mode;
            end
            r_phase <= r_href1 ? ~r_phase : 1'b0;
            if (r_href1 && !r_phase) begin
                r_hi <= r_pix1[9:2];
            end
            if (w_href_fall && r_phase && !r_mode) begin
                r_err <= 1'b1;
            end
        end
    end

    // Saturating pixel/line position counters
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            if (w_href_fall) begin
                r_h_cnt <= '0;
            end else if (w_strobe && (r_h_cnt != CNT_W'(CNT_MAX))) begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
            if (w_fs) begin
                r_v_cnt <= '0;
            end else if (w_href_fall && (r_v_cnt != CNT_W'(CNT_MAX))) begin
                r_v_cnt <= r_v_cnt + CNT_W'(1);
            end
        end
    end

    // Output registers; the entering frame's vsync is forwarded via the next state
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_n      <= 1'b1;
            r_de        <= 1'b0;
            r_data      <= '0;
            r_running   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_n    <= (w_state_nxt == S_RUN) ? ~r_vsync1 : 1'b1;
            r_de      <= w_de;
            r_running <= (r_state == S_RUN);
            if (w_de) begin
                r_data <= w_pix;
            end
            if (w_fs && (w_state_nxt == S_RUN)) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign o_fb.vs_n   = r_vs_n;
    assign o_fb.de     = r_de;
    assign o_fb.data   = r_data;
    assign O_running   = r_running;
    assign O_frame_cnt = r_frame_cnt;
    assign O_err       = r_err;

endmodule
